// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM encoding and word geometry.
package instr_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } load_state_t;

endpackage

// File: rtl/instr_loader.sv
// Streams big-endian bytes into 32-bit words and writes them to instruction memory, then releases the CPU.
// One im_we cycle after every 4th accepted byte; byte_ready is registered and drops for the write cycle.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        cpu_run
);

  localparam logic [8:0] MAX_W9 = 9'(MAX_WORDS);

  load_state_t        state;
  logic [8:0]         remaining;
  logic [31:0]        addr;
  logic [WORD_W-1:0]  word;
  logic [IDX_W-1:0]   byte_idx;
  logic [8:0]         clamped_count;
  logic [WORD_W-1:0]  next_word;

  assign clamped_count = ({1'b0, word_count} > MAX_W9) ? MAX_W9 : {1'b0, word_count};
  assign next_word     = {word[WORD_W-9:0], byte_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      addr       <= ADDR_BASE;
      word       <= '0;
      byte_idx   <= '0;
      byte_ready <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= ADDR_BASE;
      im_wdata   <= '0;
      busy       <= 1'b0;
      cpu_run    <= 1'b0;
    end else begin
      im_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (load_start) begin
            addr      <= ADDR_BASE;
            byte_idx  <= '0;
            remaining <= clamped_count;
            if (clamped_count == 9'd0) begin
              // Empty program: go straight to run without touching memory.
              state      <= ST_DONE;
              cpu_run    <= 1'b1;
              busy       <= 1'b0;
              byte_ready <= 1'b0;
            end else begin
              state      <= ST_RECV;
              cpu_run    <= 1'b0;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end

        ST_RECV: begin
          if (byte_valid) begin
            word     <= next_word;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == IDX_W'(BYTES_PER_WORD - 1)) begin
              state      <= ST_WRITE;
              byte_ready <= 1'b0;
              im_we      <= 1'b1;
              im_addr    <= addr;
              im_wdata   <= next_word;
            end
          end
        end

        ST_WRITE: begin
          addr      <= addr + 32'd4;
          remaining <= remaining - 9'd1;
          byte_idx  <= '0;
          if (remaining == 9'd1) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            cpu_run <= 1'b1;
          end else begin
            state      <= ST_RECV;
            byte_ready <= 1'b1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          cpu_run    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0000_0000, byte address written by the first loaded word.
REQ-002 Parameter MAX_WORDS, default 64, instruction-memory capacity in 32-bit words (1..256).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_start  input  1  one-cycle request to begin a load.
REQ-006 word_count  input  8  number of words to load, sampled on accepted load_start.
REQ-007 byte_valid  input  1  byte_data holds a valid byte.
REQ-008 byte_data  input  8  program byte stream, big-endian within each word.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle (transfer = byte_valid & byte_ready).
REQ-010 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 im_addr  output  32  instruction-memory byte address, valid while im_we high.
REQ-012 im_wdata  output  32  assembled instruction word, valid while im_we high.
REQ-013 busy  output  1  load in progress (RECV or WRITE).
REQ-014 cpu_run  output  1  program loaded; CPU clock-enable / release of hold.

Function
REQ-015 States: IDLE, RECV, WRITE, DONE; encoding in shared package.
REQ-016 IDLE: byte_ready=0; load_start -> RECV, latch count=min(word_count, MAX_WORDS), addr=ADDR_BASE, byte index=0.
REQ-017 IDLE/DONE with clamped count 0: load_start -> DONE next cycle, no im_we pulse.
REQ-018 RECV: byte_ready=1; each transfer shifts byte into word, first byte -> [31:24], fourth -> [7:0].
REQ-019 Fourth transfer at edge N -> WRITE; im_we=1 during cycle N+1 with im_addr=current addr, im_wdata=assembled word.
REQ-020 WRITE: byte_ready=0; lasts exactly one cycle; addr += 4, remaining count -= 1.
REQ-021 WRITE with remaining count becoming 0 -> DONE; otherwise -> RECV, byte index=0.
REQ-022 DONE: cpu_run=1, byte_ready=0, busy=0; holds until reset or load_start.
REQ-023 load_start in DONE: cpu_run drops same edge as entering RECV (restart reload).
REQ-024 load_start while busy is ignored; no restart, no count change.
REQ-025 byte_valid without byte_ready: byte not consumed, no state change.
REQ-026 im_addr wraps modulo 2^32; no overflow flag.
REQ-027 im_we, byte_ready, busy, cpu_run are registered or decoded from state only; no combinational path from byte_valid to byte_ready.

Reset
REQ-028 reset asserted: state=IDLE, byte_ready=0, im_we=0, im_addr=ADDR_BASE, im_wdata=0, busy=0, cpu_run=0, counters=0, immediately (asynchronous).
REQ-029 Reset mid-load discards partial word; no im_we pulse issued for it.
REQ-030 First load_start honoured on first rising edge after reset deassertion.

Structure
REQ-031 Shared package holds state enumeration, word width (32) and byte-per-word (4) constants.
REQ-032 Single module; no sub-module (byte assembler inline in RECV logic).

Verification
REQ-033 Reset, word_count=2, bytes 20 01 00 05 8C 02 00 04 back-to-back -> im_we pulses: addr 0 data 32'h2001_0005, addr 4 data 32'h8C02_0004; cpu_run=1 one cycle after second write.
REQ-034 word_count=0, load_start -> DONE next cycle, cpu_run=1, zero im_we pulses.
REQ-035 word_count=200, MAX_WORDS=64, continuous bytes -> exactly 64 im_we pulses, last addr 32'h0000_00FC.
REQ-036 byte_valid toggled 1/0 every cycle, word_count=1, bytes AA BB CC DD -> single write 32'hAABB_CCDD; byte_ready low during WRITE cycle.
REQ-037 reset asserted after 2 of 4 bytes -> immediate IDLE, outputs at reset values, no write; fresh load of word 32'h1234_5678 lands at ADDR_BASE.
REQ-038 load_start pulsed during RECV -> ignored; load_start in DONE -> cpu_run=0, reload begins at ADDR_BASE.
